pcs_sync: RTL
=============

# pcs_sync

Receive-side code-group synchronization stage for the 1000BASE-X PCS. It sits directly downstream of the deserializer and mirrors the `transmit` 8B/10B encoder path. It consumes raw 10-bit code groups, aligns to K28.5 commas, and qualifies each group. It also runs the synchronization state machine that drives `sync_status` and `rx_even` for the receive decoder.

## Interface
- `GOOD_CGS_MAX`, default 3: consecutive good groups needed to clear one error level.
- `GTX_CLK`  in  1  clock; all logic on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `SIGNAL_DETECT`  in  1  PMD signal present.
- `rx_code_group`  in  10  received group; bit 9 = a … bit 0 = j, the same order the encoder uses.
- `rx_code_group_q`  out  10  `rx_code_group` delayed one cycle.
- `sync_status`  out  1  1 = OK, 0 = FAIL.
- `rx_even`  out  1  parity label of the group now on `rx_code_group_q` (1 = even).
- `cg_bad`  out  1  the group on `rx_code_group_q` was classified bad.

## Operation
- Group classification is combinational on `rx_code_group`:
  - comma: bits[9:3] equal 7'b0011111 or 7'b1100000.
  - good: ones count is 4, 5 or 6, and no run of more than 5 identical adjacent bits.
  - bad: not good, or a comma arriving on an odd-labelled slot.
- Parity label:
  - An accepted comma is labelled even.
  - Labels alternate every cycle after that.
  - In LOSS_OF_SYNC the label toggles freely.
- State machine, one transition per cycle:
  - LOSS_OF_SYNC: on comma → COMMA_DETECT_1.
  - COMMA_DETECT_1/2/3: if the group is good and not a comma, go to ACQUIRE_SYNC_1, ACQUIRE_SYNC_2 or SYNC_ACQUIRED_1 respectively. Otherwise → LOSS_OF_SYNC.
  - ACQUIRE_SYNC_1/2:
    - bad group → LOSS_OF_SYNC.
    - comma on an even slot → COMMA_DETECT_2 or COMMA_DETECT_3 respectively.
    - otherwise stay.
  - SYNC_ACQUIRED_1: bad → SYNC_ACQUIRED_2.
  - SYNC_ACQUIRED_n (n = 2, 3, 4):
    - Entry clears good_cgs.
    - Good group → SYNC_ACQUIRED_nA with good_cgs = 1.
    - Bad group → SYNC_ACQUIRED_n+1; from n = 4 → LOSS_OF_SYNC.
  - SYNC_ACQUIRED_nA:
    - Good group increments good_cgs (2 bits, saturating).
    - When the group is good and good_cgs = GOOD_CGS_MAX → SYNC_ACQUIRED_n-1.
    - Bad group → SYNC_ACQUIRED_n+1; from 4A → LOSS_OF_SYNC.
- `sync_status` = 1 in all SYNC_ACQUIRED_* states, 0 elsewhere.
- `SIGNAL_DETECT` = 0 forces LOSS_OF_SYNC on the next edge from any state. This overrides every other transition.

## Timing
- Every output is registered.
- `rx_code_group_q`, `rx_even` and `cg_bad` lag `rx_code_group` by exactly 1 cycle.
- `sync_status` reflects the state entered at the edge that sampled the group.
- Reset values:
  - state = LOSS_OF_SYNC
  - `sync_status` = 0, `rx_even` = 0, `cg_bad` = 0
  - `rx_code_group_q` = 10'b0000000000
  - good_cgs = 0
  - running disparity = negative
- `RESET` has priority over `SIGNAL_DETECT` and over all transitions. A reset asserted mid-sync drops `sync_status` at the next edge.
- Minimum acquisition: 6 groups (comma, D, comma, D, comma, D). `sync_status` rises at the edge that samples group 6.
- Minimum loss from SYNC_ACQUIRED_1: 4 consecutive bad groups. `sync_status` falls at the edge that samples the 4th.

## Configuration
- Macro: `PCS_SYNC_RD_CHECK_EN`.
- With the macro defined, running disparity is tracked:
  - 6 ones → RD+; 4 ones → RD−; 5 ones leaves RD unchanged.
  - A 6-ones group received while RD+, or a 4-ones group while RD−, is bad.
  - RD resets to negative and is re-initialised from the comma on COMMA_DETECT_1 entry.
- Without the macro:
  - Only the structural check applies.
  - No RD register is built.

## Structure
- Shared package `pcs_pkg` holds:
  - the state enum (13 states);
  - `K28_5_RDN` = 10'b0011111010 and `K28_5_RDP` = 10'b1100000101;
  - the comma prefixes. The encoder reuses the same constants.
- One sub-module, `cg_classify`: combinational; produces comma, ones count and good flags.

## Test plan
- Reset, then continuous D0.0 RD− (10'b1001110100): `sync_status` stays 0, state LOSS_OF_SYNC.
- Idle stream K28.5 (10'b0011111010) / D16.2 (10'b1001000101), repeated: `sync_status` = 1 after the 6th group and stays 1. `rx_even` = 1 on each K28.5.
- In sync, insert one 10'b1111111111 then 3 good groups: `cg_bad` pulses once, `sync_status` stays 1, state returns to SYNC_ACQUIRED_1.
- In sync, insert 4 consecutive 10'b0000000000: `sync_status` drops at the edge that samples the 4th.
- During acquisition, a K28.5 on an odd slot in ACQUIRE_SYNC_1 → LOSS_OF_SYNC, `sync_status` stays 0.
- In sync, pulse `RESET` for 1 cycle, or drop `SIGNAL_DETECT`: next edge `sync_status` = 0 and `rx_even` = 0 (reset case). Re-acquisition takes 6 further groups.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared 1000BASE-X PCS constants: code-group synchronization states and K28.5 comma values.
// The receive synchronizer and the transmit encoder both use these constants.
package pcs_pkg;

  typedef enum logic [3:0] {
    LOSS_OF_SYNC     = 4'd0,
    COMMA_DETECT_1   = 4'd1,
    COMMA_DETECT_2   = 4'd2,
    COMMA_DETECT_3   = 4'd3,
    ACQUIRE_SYNC_1   = 4'd4,
    ACQUIRE_SYNC_2   = 4'd5,
    SYNC_ACQUIRED_1  = 4'd6,
    SYNC_ACQUIRED_2  = 4'd7,
    SYNC_ACQUIRED_3  = 4'd8,
    SYNC_ACQUIRED_4  = 4'd9,
    SYNC_ACQUIRED_2A = 4'd10,
    SYNC_ACQUIRED_3A = 4'd11,
    SYNC_ACQUIRED_4A = 4'd12
  } pcs_sync_state_e;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  // Seven-bit comma prefixes (bits a..g) of the two K28.5 disparities.
  localparam logic [6:0] COMMA_PREFIX_RDN = K28_5_RDN[9:3];
  localparam logic [6:0] COMMA_PREFIX_RDP = K28_5_RDP[9:3];

  function automatic logic is_sync_state(input pcs_sync_state_e s);
    case (s)
      SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4,
      SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cg_classify.sv
// Combinational 10-bit code-group classifier: comma prefix match, ones count,
// and structural validity (ones count 4..6, no run longer than five bits).
module cg_classify
  import pcs_pkg::*;
(
  input  logic [9:0] cg,
  output logic       comma,
  output logic [3:0] ones,
  output logic       good
);

  logic [4:0] run6;

  // A six-bit window that is all ones or all zeros marks an over-long run.
  for (genvar gi = 0; gi < 5; gi++) begin : g_run
    assign run6[gi] = (&cg[gi+5:gi]) | ~(|cg[gi+5:gi]);
  end

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, cg[i]};
    end
  end

  assign comma = (cg[9:3] == COMMA_PREFIX_RDN) || (cg[9:3] == COMMA_PREFIX_RDP);
  assign good  = (ones >= 4'd4) && (ones <= 4'd6) && (run6 == 5'b00000);

endmodule

// File: rtl/pcs_sync.sv
// 1000BASE-X receive code-group synchronization: comma alignment, group qualification,
// sync state machine. Define PCS_SYNC_RD_CHECK_EN to add running-disparity checking.
module pcs_sync
  import pcs_pkg::*;
#(
  parameter int GOOD_CGS_MAX = 3
) (
  input  logic       GTX_CLK,
  input  logic       RESET,
  input  logic       SIGNAL_DETECT,
  input  logic [9:0] rx_code_group,
  output logic [9:0] rx_code_group_q,
  output logic       sync_status,
  output logic       rx_even,
  output logic       cg_bad
);

  localparam logic [1:0] CGS_MAX = 2'(GOOD_CGS_MAX);

  pcs_sync_state_e state_q, state_d;
  logic [1:0]      good_cgs_q, good_cgs_d;
  logic [1:0]      cgs_inc;
  logic [9:0]      rx_code_group_d;
  logic            sync_status_q, sync_status_d;
  logic            rx_even_q, rx_even_d;
  logic            cg_bad_q, cg_bad_d;

  logic            comma_w;
  logic [3:0]      ones_w;
  logic            struct_good_w;
  logic            comma_accept;
  logic            rd_err;
  logic            cg_good_w;
  logic            cg_bad_w;

  cg_classify u_classify (
    .cg    (rx_code_group),
    .comma (comma_w),
    .ones  (ones_w),
    .good  (struct_good_w)
  );

  // A comma seen while out of sync is taken as the new even-slot reference.
  assign comma_accept = (state_q == LOSS_OF_SYNC) && comma_w && SIGNAL_DETECT;

`ifdef PCS_SYNC_RD_CHECK_EN
  logic rd_pos_q, rd_pos_d;

  always_comb begin
    rd_err   = !comma_accept &&
               (((ones_w == 4'd6) && rd_pos_q) || ((ones_w == 4'd4) && !rd_pos_q));
    rd_pos_d = rd_pos_q;
    if (comma_accept) begin
      rd_pos_d = (ones_w == 4'd6);
    end else if (ones_w == 4'd6) begin
      rd_pos_d = 1'b1;
    end else if (ones_w == 4'd4) begin
      rd_pos_d = 1'b0;
    end
  end

  always_ff @(posedge GTX_CLK) begin
    if (RESET) begin
      rd_pos_q <= 1'b0;
    end else begin
      rd_pos_q <= rd_pos_d;
    end
  end
`else
  logic unused_ones;
  assign unused_ones = ^ones_w;
  assign rd_err      = 1'b0;
`endif

  // rx_even_q labels the previous group, so a comma now lands on an odd slot when it is set.
  assign cg_good_w = struct_good_w && !rd_err;
  assign cg_bad_w  = !cg_good_w || (comma_w && rx_even_q && (state_q != LOSS_OF_SYNC));
  assign cgs_inc   = (good_cgs_q == 2'd3) ? 2'd3 : good_cgs_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    good_cgs_d = good_cgs_q;
    case (state_q)
      LOSS_OF_SYNC:   if (comma_w) state_d = COMMA_DETECT_1;
      COMMA_DETECT_1: state_d = (cg_good_w && !comma_w) ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
      COMMA_DETECT_2: state_d = (cg_good_w && !comma_w) ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
      COMMA_DETECT_3: state_d = (cg_good_w && !comma_w) ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
      ACQUIRE_SYNC_1: begin
        if (cg_bad_w)     state_d = LOSS_OF_SYNC;
        else if (comma_w) state_d = COMMA_DETECT_2;
      end
      ACQUIRE_SYNC_2: begin
        if (cg_bad_w)     state_d = LOSS_OF_SYNC;
        else if (comma_w) state_d = COMMA_DETECT_3;
      end
      SYNC_ACQUIRED_1: begin
        if (cg_bad_w) begin
          state_d    = SYNC_ACQUIRED_2;
          good_cgs_d = 2'd0;
        end
      end
      SYNC_ACQUIRED_2: begin
        state_d    = cg_bad_w ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
        good_cgs_d = cg_bad_w ? 2'd0 : 2'd1;
      end
      SYNC_ACQUIRED_3: begin
        state_d    = cg_bad_w ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
        good_cgs_d = cg_bad_w ? 2'd0 : 2'd1;
      end
      SYNC_ACQUIRED_4: begin
        state_d    = cg_bad_w ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
        good_cgs_d = cg_bad_w ? 2'd0 : 2'd1;
      end
      SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
        if (cg_bad_w) begin
          good_cgs_d = 2'd0;
          case (state_q)
            SYNC_ACQUIRED_2A: state_d = SYNC_ACQUIRED_3;
            SYNC_ACQUIRED_3A: state_d = SYNC_ACQUIRED_4;
            default:          state_d = LOSS_OF_SYNC;
          endcase
        end else if (cgs_inc == CGS_MAX) begin
          good_cgs_d = 2'd0;
          case (state_q)
            SYNC_ACQUIRED_2A: state_d = SYNC_ACQUIRED_1;
            SYNC_ACQUIRED_3A: state_d = SYNC_ACQUIRED_2;
            default:          state_d = SYNC_ACQUIRED_3;
          endcase
        end else begin
          good_cgs_d = cgs_inc;
        end
      end
      default: state_d = LOSS_OF_SYNC;
    endcase

    // Losing the PMD signal overrides whatever the group stream would do.
    if (!SIGNAL_DETECT) begin
      state_d    = LOSS_OF_SYNC;
      good_cgs_d = 2'd0;
    end
  end

  always_comb begin
    rx_code_group_d = rx_code_group;
    rx_even_d       = comma_accept ? 1'b1 : !rx_even_q;
    cg_bad_d        = cg_bad_w;
    sync_status_d   = is_sync_state(state_d);
  end

  always_ff @(posedge GTX_CLK) begin
    if (RESET) begin
      state_q         <= LOSS_OF_SYNC;
      good_cgs_q      <= 2'd0;
      rx_code_group_q <= 10'b0000000000;
      sync_status_q   <= 1'b0;
      rx_even_q       <= 1'b0;
      cg_bad_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      good_cgs_q      <= good_cgs_d;
      rx_code_group_q <= rx_code_group_d;
      sync_status_q   <= sync_status_d;
      rx_even_q       <= rx_even_d;
      cg_bad_q        <= cg_bad_d;
    end
  end

  assign sync_status = sync_status_q;
  assign rx_even     = rx_even_q;
  assign cg_bad      = cg_bad_q;

endmodule
